// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_unit_pkg;
  localparam int DATA_WIDTH         = 32;
  localparam int MULDIV_DIV_LATENCY = DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  // ST_ prefix keeps state names clear of the MUL/DIV opcode literals
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} muldiv_state_e;

  function automatic logic op_a_signed(muldiv_op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(muldiv_op_e op);
    return op inside {MULH, DIV, REM};
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake between the execute stage and the mul/div unit.
interface muldiv_if import muldiv_unit_pkg::*; #(
  parameter int XLEN = DATA_WIDTH
);
  logic            in_valid_i;
  logic            in_ready_o;
  muldiv_op_e      op_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            kill_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output in_valid_i, op_i, op_a_i, op_b_i, kill_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );
  modport slave (
    input  in_valid_i, op_i, op_a_i, op_b_i, kill_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Unsigned radix-2 restoring divider; the first quotient bit retires on the start edge.
module div_core import muldiv_unit_pkg::*; #(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quot_q, div_q;
  logic [XLEN-1:0] src_r, src_q, src_d, nxt_r, nxt_q;
  logic [XLEN:0]   r2, diff;

  // quot_q shifts dividend bits out at the top and quotient bits in at the bottom
  always_comb begin
    src_r = start ? '0 : rem_q;
    src_q = start ? dividend : quot_q;
    src_d = start ? divisor : div_q;
    r2    = {src_r, src_q[XLEN-1]};
    diff  = r2 - {1'b0, src_d};
    nxt_r = diff[XLEN] ? r2[XLEN-1:0] : diff[XLEN-1:0];
    nxt_q = {src_q[XLEN-2:0], ~diff[XLEN]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done   <= 1'b0;
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
    end else if (start) begin
      rem_q  <= nxt_r;
      quot_q <= nxt_q;
      div_q  <= divisor;
      cnt    <= CW'(1);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      rem_q  <= nxt_r;
      quot_q <= nxt_q;
      if (cnt == CW'(XLEN-1)) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier, iterative divider, kill and output backpressure.
module muldiv_unit import muldiv_unit_pkg::*; #(
  parameter int XLEN       = DATA_WIDTH,
  parameter int MUL_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_e     state;
  muldiv_op_e        op_q, op_sel;
  logic [CW-1:0]     cnt;
  logic              q_neg_q, r_neg_q;
  logic              a_neg, b_neg, div_by0, ovf, accept, div_start, div_done;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, quot, rem, mul_res;
  logic [2*XLEN-1:0] prod, mul_tap;

  assign a_neg   = op_a_signed(bus.op_i) & bus.op_a_i[XLEN-1];
  assign b_neg   = op_b_signed(bus.op_i) & bus.op_b_i[XLEN-1];
  assign prod    = {{XLEN{a_neg}}, bus.op_a_i} * {{XLEN{b_neg}}, bus.op_b_i};
  assign a_mag   = a_neg ? -bus.op_a_i : bus.op_a_i;
  assign b_mag   = b_neg ? -bus.op_b_i : bus.op_b_i;

  assign div_by0  = (bus.op_b_i == '0);
  assign ovf      = (bus.op_i inside {DIV, REM}) && (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (&bus.op_b_i);
  assign spec_res = bus.op_i[1] ? (div_by0 ? bus.op_a_i : '0) : (div_by0 ? '1 : bus.op_a_i);

  assign accept    = (state == ST_IDLE) & bus.in_valid_i & ~bus.kill_i;
  assign div_start = accept & bus.op_i[2] & ~div_by0 & ~ovf;

  // Product is captured on accept and walks a retimable register chain to the result register
  generate
    if (MUL_CYCLES == 1) begin : g_nopipe
      assign mul_tap = prod;
    end else begin : g_pipe
      logic [2*XLEN-1:0] pipe [MUL_CYCLES-1];
      always_ff @(posedge clk) begin
        if (accept) pipe[0] <= prod;
        for (int i = 1; i < MUL_CYCLES-1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_tap = pipe[MUL_CYCLES-2];
    end
  endgenerate

  assign op_sel  = (state == ST_IDLE) ? bus.op_i : op_q;
  assign mul_res = (op_sel == MUL) ? mul_tap[XLEN-1:0] : mul_tap[2*XLEN-1:XLEN];

  div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quot     (quot),
    .rem      (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_q            <= MUL;
      cnt             <= '0;
      q_neg_q         <= 1'b0;
      r_neg_q         <= 1'b0;
      bus.in_ready_o  <= 1'b1;
      bus.out_valid_o <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.result_o    <= '0;
    end else if (bus.kill_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bus.in_ready_o  <= 1'b1;
      bus.out_valid_o <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid_i) begin
          op_q           <= bus.op_i;
          q_neg_q        <= a_neg ^ b_neg;
          r_neg_q        <= a_neg;
          bus.in_ready_o <= 1'b0;
          bus.busy_o     <= 1'b1;
          if (!bus.op_i[2]) begin
            if (MUL_CYCLES == 1) begin
              bus.result_o    <= mul_res;
              bus.out_valid_o <= 1'b1;
              state           <= ST_DONE;
            end else begin
              cnt   <= CW'(MUL_CYCLES-1);
              state <= ST_MUL;
            end
          end else if (div_by0 || ovf) begin
            bus.result_o    <= spec_res;
            bus.out_valid_o <= 1'b1;
            state           <= ST_DONE;
          end else begin
            cnt   <= CW'(XLEN-1);
            state <= ST_DIV;
          end
        end
        ST_MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bus.result_o    <= mul_res;
            bus.out_valid_o <= 1'b1;
            state           <= ST_DONE;
          end
        end
        // Counter ends the DIV state on the edge the core retires its last bit
        ST_DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: if (div_done) begin
          if (op_q[1]) bus.result_o <= r_neg_q ? -rem : rem;
          else         bus.result_o <= q_neg_q ? -quot : quot;
          bus.out_valid_o <= 1'b1;
          state           <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready_i) begin
          bus.out_valid_o <= 1'b0;
          bus.in_ready_o  <= 1'b1;
          bus.busy_o      <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
